// File: rtl/led_bank_if.sv
// Bus between the LED bank arbiter and its requesters: level requests,
// packed per-requester patterns, and the registered grant/led/busy outputs.
interface led_bank_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 5
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] pat;
  logic [NREQ-1:0]       grant;
  logic [WIDTH-1:0]      led;
  logic                  busy;

  // Requester side drives requests and patterns, observes the bank.
  modport master (output req, pat, input grant, led, busy);
  // Arbiter side.
  modport slave  (input req, pat, output grant, led, busy);
endinterface

// File: rtl/led_bank_arbiter.sv
// Round-robin arbiter sharing one LED bank among NREQ requesters.
// Each owner keeps the bank for at least DWELL cycles unless it releases it;
// a one-cycle blank gap (IDLE_PATTERN) separates owners.
// Optional build macro LED_BANK_ARB_BLINK_EN: the unowned bank blinks between
// IDLE_PATTERN and all-off with period 2*DWELL instead of a steady IDLE_PATTERN.
module led_bank_arbiter #(
  parameter int               NREQ         = 4,
  parameter int               WIDTH        = 5,
  parameter int               DWELL        = 12000000,
  parameter logic [WIDTH-1:0] IDLE_PATTERN = WIDTH'(5'b01111)
) (
  input  logic     clk,
  input  logic     rst_n,
  led_bank_if.slave bus
);

  localparam int               CW        = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]    CNT_MAX   = CW'(DWELL - 1);
  localparam logic [NREQ-1:0]  LAST_INIT = {1'b1, {(NREQ-1){1'b0}}};
  localparam logic [NREQ-1:0]  ONE_N     = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  last_q,  last_d;   // one-hot last owner, kept through GAP/IDLE
  logic [WIDTH-1:0] led_q,   led_d;
  logic             busy_q,  busy_d;
  logic [CW-1:0]    cnt_q,   cnt_d;

  logic [NREQ-1:0]  win_oh;
  logic [WIDTH-1:0] pat_sel;
  logic [WIDTH-1:0] idle_led;
  logic [WIDTH-1:0] pat_masked [NREQ];

  // Each requester's pattern, zeroed unless that requester currently owns the bank.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_pat
    assign pat_masked[gi] = bus.pat[gi*WIDTH +: WIDTH] & {WIDTH{grant_q[gi]}};
  end

  // OR of the masked patterns: the owner's pattern, or zero when unowned.
  always_comb begin
    pat_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      pat_sel = pat_sel | pat_masked[i];
    end
  end

  // Round-robin pick: lowest request strictly above the last owner, else lowest overall,
  // so the previous owner comes last in rotation order.
  always_comb begin
    logic [NREQ-1:0] upto_last;
    logic [NREQ-1:0] req_hi;
    logic [NREQ-1:0] cand;
    upto_last = {last_q[NREQ-2:0], 1'b0} - ONE_N;
    req_hi    = bus.req & ~upto_last;
    cand      = (|req_hi) ? req_hi : bus.req;
    win_oh    = cand & (~cand + ONE_N);
  end

`ifdef LED_BANK_ARB_BLINK_EN
  logic [CW-1:0] blink_cnt_q;
  logic          blink_q;

  // Free-running heartbeat toggle, flipping every DWELL cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (blink_cnt_q == CNT_MAX) begin
      blink_cnt_q <= '0;
      blink_q     <= ~blink_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + CW'(1);
    end
  end

  assign idle_led = blink_q ? IDLE_PATTERN : '0;
`else
  assign idle_led = IDLE_PATTERN;
`endif

  // Next-state and registered-output decisions for IDLE / OWN / GAP.
  always_comb begin
    logic owner_req;
    logic contender;
    logic expired;
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    led_d     = led_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    owner_req = |(bus.req & grant_q);
    contender = |(bus.req & ~grant_q);
    expired   = (cnt_q == CNT_MAX);
    unique case (state_q)
      S_OWN: begin
        if (!owner_req || (expired && contender)) begin
          state_d = S_GAP;
          grant_d = '0;
          busy_d  = 1'b0;
          led_d   = idle_led;
        end else begin
          led_d = pat_sel;
          if (!expired) cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        // IDLE and GAP arbitrate identically; the bank stays blank this cycle.
        led_d   = idle_led;
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (|bus.req) begin
          state_d = S_OWN;
          grant_d = win_oh;
          last_d  = win_oh;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // State and output registers; reset puts the bank straight back to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= LAST_INIT;
      led_q   <= IDLE_PATTERN;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.led   = led_q;
  assign bus.busy  = busy_q;

endmodule
